// File: rtl/word_serializer.sv
// Width-down converter: one IN_W-bit word in, IN_W/OUT_W chunks of OUT_W bits out.
// Chunk order is MSB-first unless LSB_FIRST is set. Back-to-back words stream with no bubble.
module word_serializer #(
    parameter  int IN_W      = 128,
    parameter  int OUT_W     = 32,
    parameter  bit LSB_FIRST = 1'b0,
    localparam int N         = IN_W / OUT_W,
    localparam int IW        = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_chunk,
    output logic [IW-1:0]    out_idx,
    output logic             out_last
);

    // Handshake rule, both ports: a transfer happens on a rising edge where valid && ready.
    // out_valid never drops without a transfer; in_ready depends only on state and out_ready.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [IN_W-1:0]    word_q, word_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [OUT_W-1:0]   chunk_q, chunk_d;
    logic               last_q, last_d;
    logic [IW-1:0]      idx_nxt;
    logic               in_xfer;
    logic               out_xfer;

    // Chunk k of a word, honouring the configured ordering.
    function automatic logic [OUT_W-1:0] pick(input logic [IN_W-1:0] w, input logic [IW-1:0] k);
        logic [OUT_W-1:0] r;
        r = '0;
        for (int j = 0; j < N; j++) begin
            if (int'(k) == j) begin
                r = LSB_FIRST ? w[j*OUT_W +: OUT_W] : w[(N-1-j)*OUT_W +: OUT_W];
            end
        end
        return r;
    endfunction

    assign in_ready  = (state_q == IDLE) || (last_q && out_ready);
    assign out_valid = (state_q == SEND);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign idx_nxt   = idx_q + IW'(1);

    assign out_chunk = chunk_q;
    assign out_idx   = idx_q;
    assign out_last  = last_q;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        chunk_d = chunk_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (in_xfer) begin
                    state_d = SEND;
                    word_d  = in_word;
                    idx_d   = '0;
                    chunk_d = pick(in_word, '0);
                    last_d  = (N == 1);
                end
            end
            SEND: begin
                if (out_xfer && !last_q) begin
                    idx_d   = idx_nxt;
                    chunk_d = pick(word_q, idx_nxt);
                    last_d  = (idx_nxt == IW'(N - 1));
                end else if (in_xfer) begin
                    // Last chunk leaves while the next word arrives: reload without a bubble.
                    word_d  = in_word;
                    idx_d   = '0;
                    chunk_d = pick(in_word, '0);
                    last_d  = (N == 1);
                end else if (out_xfer) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            chunk_q <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            chunk_q <= chunk_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: a 128/32 MSB-first instance and a 32/8 LSB-first instance
// checked every cycle against a queue-based model of the expected chunk stream.
module tb_word_serializer;

    localparam int AN = 4;
    localparam int AO = 32;
    localparam int BN = 4;
    localparam int BO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0, a_out_last;
    logic [127:0] a_in_word = '0;
    logic [31:0]  a_out_chunk;
    logic [1:0]   a_out_idx;

    logic         b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_out_last;
    logic [31:0]  b_in_word = '0;
    logic [7:0]   b_out_chunk;
    logic [1:0]   b_out_idx;

    word_serializer #(.IN_W(128), .OUT_W(32), .LSB_FIRST(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_word(a_in_word),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_chunk(a_out_chunk),
        .out_idx(a_out_idx), .out_last(a_out_last)
    );

    word_serializer #(.IN_W(32), .OUT_W(8), .LSB_FIRST(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_word(b_in_word),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_chunk(b_out_chunk),
        .out_idx(b_out_idx), .out_last(b_out_last)
    );

    int total = 0;
    int bad   = 0;

    // Expected stream entries packed as {last, idx, chunk}.
    logic [34:0] a_q[$];
    logic [10:0] b_q[$];
    bit          a_hold = 1'b0, b_hold = 1'b0;
    logic [34:0] a_saved;
    logic [10:0] b_saved;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_a(input logic [127:0] w);
        for (int i = 0; i < AN; i++)
            a_q.push_back({(i == AN - 1), 2'(i), 32'(w >> (AO * (AN - 1 - i)))});
    endtask

    task automatic push_b(input logic [31:0] w);
        for (int i = 0; i < BN; i++)
            b_q.push_back({(i == BN - 1), 2'(i), 8'(w >> (BO * i))});
    endtask

    // One clock cycle: drive both instances, check against the model, advance to next negedge.
    task automatic step(input bit av, input logic [127:0] aw, input bit ar,
                        input bit bv, input logic [31:0] bw, input bit br,
                        output bit a_acc, output bit b_acc);
        logic [34:0] obs_a;
        logic [10:0] obs_b;
        bit          rdy;
        a_in_valid = av; a_in_word = aw; a_out_ready = ar;
        b_in_valid = bv; b_in_word = bw; b_out_ready = br;
        #1;
        obs_a = {a_out_last, a_out_idx, a_out_chunk};
        if (a_hold) chk("a_stall_hold", obs_a, a_saved);
        rdy = (a_q.size() == 0) || (a_q.size() <= AN && a_q.size() == 1 && ar);
        chk("a_in_ready", a_in_ready, rdy);
        chk("a_out_valid", a_out_valid, a_q.size() > 0);
        a_hold  = (a_q.size() > 0) && !ar;
        a_saved = obs_a;
        if (a_q.size() > 0 && ar) chk("a_chunk", obs_a, a_q.pop_front());
        a_acc = av && rdy;
        if (a_acc) push_a(aw);

        obs_b = {b_out_last, b_out_idx, b_out_chunk};
        if (b_hold) chk("b_stall_hold", obs_b, b_saved);
        rdy = (b_q.size() == 0) || (b_q.size() == 1 && br);
        chk("b_in_ready", b_in_ready, rdy);
        chk("b_out_valid", b_out_valid, b_q.size() > 0);
        b_hold  = (b_q.size() > 0) && !br;
        b_saved = obs_b;
        if (b_q.size() > 0 && br) chk("b_chunk", obs_b, b_q.pop_front());
        b_acc = bv && rdy;
        if (b_acc) push_b(bw);
        @(negedge clk);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset();
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_a_out_valid", a_out_valid, 0);
        chk("rst_a_out_chunk", a_out_chunk, 0);
        chk("rst_a_out_idx", a_out_idx, 0);
        chk("rst_a_out_last", a_out_last, 0);
        chk("rst_a_in_ready", a_in_ready, 1);
        chk("rst_b_out_valid", b_out_valid, 0);
        chk("rst_b_out_chunk", b_out_chunk, 0);
        chk("rst_b_in_ready", b_in_ready, 1);
        a_q.delete(); b_q.delete();
        a_hold = 1'b0; b_hold = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        bit x, y;
        int cyc = 0;
        while ((a_q.size() > 0 || b_q.size() > 0) && cyc < 200) begin
            step(1'b0, '0, 1'b1, 1'b0, '0, 1'b1, x, y);
            cyc++;
        end
        chk("drain_timeout", cyc < 200, 1);
    endtask

    initial begin
        bit           aa, ba;
        int           k, cyc, ka, kb;
        logic [127:0] wa[3];
        logic [127:0] wr;
        logic [31:0]  wb;

        @(negedge clk);
        do_reset();
        step(1'b0, '0, 1'b1, 1'b0, '0, 1'b1, aa, ba);

        // Directed words on both instances.
        step(1'b1, 128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b1,
             1'b1, 32'hA1B2C3D4, 1'b1, aa, ba);
        chk("basic_a_accept", aa, 1);
        chk("basic_b_accept", ba, 1);
        drain();

        // Three back-to-back words with ready held high: 1 load cycle + 12 chunk cycles.
        for (int i = 0; i < 3; i++) wa[i] = {$urandom, $urandom, $urandom, $urandom};
        k = 0; cyc = 0;
        while ((k < 3 || a_q.size() > 0) && cyc < 100) begin
            step(k < 3, wa[(k < 3) ? k : 0], 1'b1, 1'b0, '0, 1'b1, aa, ba);
            if (aa) k++;
            cyc++;
        end
        chk("a_b2b_cycles", cyc, 13);

        // Random valid/backpressure on both instances.
        ka = 0; kb = 0; cyc = 0;
        wr = {$urandom, $urandom, $urandom, $urandom};
        wb = $urandom;
        while ((ka < 8 || kb < 8 || a_q.size() > 0 || b_q.size() > 0) && cyc < 3000) begin
            step((ka < 8) && ($urandom_range(0, 3) != 0), wr, 1'($urandom_range(0, 1)),
                 (kb < 8) && ($urandom_range(0, 3) != 0), wb, 1'($urandom_range(0, 2) != 0),
                 aa, ba);
            if (aa) begin ka++; wr = {$urandom, $urandom, $urandom, $urandom}; end
            if (ba) begin kb++; wb = $urandom; end
            cyc++;
        end
        chk("bp_timeout", cyc < 3000, 1);

        // Reset after chunk 1 of a word; the remainder must never appear.
        step(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1, $urandom, 1'b1, aa, ba);
        step(1'b0, '0, 1'b1, 1'b0, '0, 1'b1, aa, ba);
        step(1'b0, '0, 1'b1, 1'b0, '0, 1'b1, aa, ba);
        do_reset();
        step(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1, $urandom, 1'b1, aa, ba);
        chk("post_rst_a_accept", aa, 1);
        chk("post_rst_b_accept", ba, 1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/word_serializer.md
# word_serializer

Parametrised, sequential width-down converter. It accepts one IN_W-bit word per valid/ready handshake and emits it as IN_W/OUT_W chunks of OUT_W bits, one per output handshake. Chunk order is MSB-first by default, so chunk 0 is the top slice (the 128→32 and 32→8 byte/word-split order the datapath already uses); LSB-first is selectable. It sits between wide producers (128-bit state, 32-bit columns) and narrower consumers. It streams back-to-back words with no bubbles and fully supports backpressure.

## Interface
- IN_W, default 128: input word width; must be an integer multiple of OUT_W.
- OUT_W, default 32: output chunk width.
- LSB_FIRST, default 0: 0 = chunk 0 is in_word[IN_W-1 -: OUT_W]; 1 = chunk 0 is in_word[OUT_W-1:0].
- Derived: N = IN_W/OUT_W; IW = max(1, clog2(N)).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_word is offered.
- in_ready  output  1  block accepts in_word this cycle.
- in_word  input  IN_W  word to serialise.
- out_valid  output  1  out_chunk is valid.
- out_ready  input  1  consumer accepts out_chunk this cycle.
- out_chunk  output  OUT_W  current chunk, registered.
- out_idx  output  IW  index of the current chunk, 0..N-1.
- out_last  output  1  high with chunk N-1.

## Operation
- Handshakes:
  - Input transfer = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
- States:
  - IDLE (out_valid=0).
  - SEND (out_valid=1).
- Internal state: an IN_W holding register (shift register or indexed mux; either is allowed) and an IW-bit chunk counter.
- in_ready = (state==IDLE) || (out_last && out_ready). This is combinational from state and out_ready. There is no combinational path from in_valid.
- IDLE, on input transfer:
  - Capture in_word.
  - out_chunk ← chunk 0; out_idx ← 0; out_last ← (N==1).
  - Go to SEND.
- SEND, on output transfer with out_last=0:
  - out_chunk ← next chunk; out_idx increments.
  - out_last ← (out_idx+1 == N-1).
- SEND, on output transfer with out_last=1:
  - If an input transfer occurs in the same cycle, load the new word exactly as from IDLE and stay in SEND. This gives zero-bubble streaming.
  - Otherwise go to IDLE: out_valid ← 0. out_chunk, out_idx and out_last keep their values.
- SEND, with out_ready=0: out_chunk, out_idx and out_last hold stable; out_valid stays 1.
- out_valid never drops without an output transfer.
- N==1: the block degenerates to a one-deep registered pipeline stage. out_last is always 1 and out_idx is always 0.
- Reset, asserted at any time, including mid-word:
  - Go to IDLE.
  - out_valid=0, out_chunk=0, out_idx=0, out_last=0, holding register=0, counter=0.
  - The partially sent word is discarded.
  - in_ready=1 while in reset and after release.

## Timing
- Latency: a word accepted at edge k presents chunk 0 on out_chunk in the cycle after edge k.
- Throughput: N cycles per word with out_ready held high, back-to-back. Sustained rate is one chunk per clock, with no idle cycle between words.
- in_ready is high for exactly one cycle per word in continuous streaming, the out_last cycle. It is high continuously in IDLE.
- Outputs are registered. out_chunk, out_idx and out_last change only on an output transfer, a word load, or reset.
- Deassertion of rst_n is treated as synchronous to clk; synchronising it is the integrator's job.

## Test plan
- Reset values: assert rst_n=0 mid-stream → out_valid=0, out_chunk=0, out_idx=0, out_last=0, in_ready=1 immediately (asynchronous), with no clk edge needed.
- Basic MSB-first (128/32): send 0x00112233_44556677_8899AABB_CCDDEEFF with out_ready=1 → chunks 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF on 4 consecutive cycles, out_idx 0..3, out_last only on the 4th.
- Back-to-back streaming: three words with in_valid held high and out_ready=1 → 12 consecutive valid chunks, no gap, in_ready high only on each out_last cycle.
- Backpressure: randomly toggle out_ready (including low on out_last) → out_chunk, out_idx and out_last stable while stalled, no chunk lost or duplicated, and the next word is not accepted until out_last transfers.
- LSB_FIRST=1, IN_W=32, OUT_W=8: send 0xA1B2C3D4 → chunks 0xD4, 0xC3, 0xB2, 0xA1.
- Reset mid-word: assert rst_n after chunk 1 of a 4-chunk word, release, then send a new word → the remainder of the old word is never emitted and the new word starts at out_idx=0.
